// File: rtl/mips_cpu_pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_pc_unit_if
// Brief    : Decision/address bundle between the controller and the PC stage.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_cpu_pc_unit_if;
    logic        clk_enable;
    logic        pcsrc;
    logic        jump;
    logic        jump1;
    logic [31:0] signimm;
    logic [25:0] instr_index;
    logic [31:0] reg_target;
    logic [31:0] instr_address;
    logic [31:0] pc_plus8;
    logic        in_delay_slot;
    logic        active;
    logic        misalign;

    // Controller side: drives decisions, consumes the fetch address and status.
    modport master (
        output clk_enable, pcsrc, jump, jump1, signimm, instr_index, reg_target,
        input  instr_address, pc_plus8, in_delay_slot, active, misalign
    );

    // PC stage side.
    modport slave (
        input  clk_enable, pcsrc, jump, jump1, signimm, instr_index, reg_target,
        output instr_address, pc_plus8, in_delay_slot, active, misalign
    );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_pc_unit
// Brief    : Fetch-side PC stage with branch delay slot and halt-on-zero.
//            Optional macro MISALIGN_TRAP_EN traps unaligned JR/JALR targets.
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  wire logic              clk,
    input  wire logic              reset,
    mips_cpu_pc_unit_if.slave      pc_bus
);

    localparam logic [1:0] c_st_run    = 2'd0;
    localparam logic [1:0] c_st_delay  = 2'd1;
    localparam logic [1:0] c_st_halted = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pending;
    logic        r_misalign;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_reg_target;
    logic [31:0] w_target;
    logic        w_transfer;
    logic        w_misalign_fault;

    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_branch_target = w_pc_plus4 + (pc_bus.signimm << 2);
    assign w_jump_target   = {w_pc_plus4[31:28], pc_bus.instr_index, 2'b00};
    assign w_transfer      = pc_bus.jump1 | pc_bus.jump | pc_bus.pcsrc;

`ifdef MISALIGN_TRAP_EN
    // Unaligned register targets never reach the pending register; they trap instead.
    assign w_reg_target     = pc_bus.reg_target;
    assign w_misalign_fault = pc_bus.jump1 & (pc_bus.reg_target[1:0] != 2'b00);
`else
    assign w_reg_target     = pc_bus.reg_target & ~32'h0000_0003;
    assign w_misalign_fault = 1'b0;
`endif

    always_comb begin
        w_target = w_pc_plus4;
        if (pc_bus.jump1)
            w_target = w_reg_target;
        else if (pc_bus.jump)
            w_target = w_jump_target;
        else if (pc_bus.pcsrc)
            w_target = w_branch_target;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_run;
            r_pc       <= RESET_VECTOR;
            r_pending  <= '0;
            r_misalign <= 1'b0;
        end else if (pc_bus.clk_enable) begin
            case (r_state)
                c_st_run: begin
                    if (w_misalign_fault) begin
                        r_state    <= c_st_halted;
                        r_misalign <= 1'b1;
                    end else begin
                        r_pc <= w_pc_plus4;
                        if (w_transfer) begin
                            r_pending <= w_target;
                            r_state   <= c_st_delay;
                        end
                    end
                end
                // Delay-slot instruction retires; any new transfer request is ignored.
                c_st_delay: begin
                    r_pc    <= r_pending;
                    r_state <= (r_pending == HALT_ADDR) ? c_st_halted : c_st_run;
                end
                c_st_halted: begin
                    r_state <= c_st_halted;
                end
                default: begin
                    r_state <= c_st_run;
                end
            endcase
        end
    end

    assign pc_bus.instr_address = r_pc;
    assign pc_bus.pc_plus8      = r_pc + 32'd8;
    assign pc_bus.in_delay_slot = (r_state == c_st_delay);
    assign pc_bus.active        = (r_state != c_st_halted);
    assign pc_bus.misalign      = r_misalign;

endmodule
`default_nettype wire
